// File: rtl/csa_subtractor_pipe16.sv
// 16-bit subtractor computed as a + ~b + ~bin, resolved one nibble per stage
// with carry-select nibbles and a valid/ready pipeline that collapses bubbles.
module csa_subtractor_pipe16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  // Carry-select nibble: both sums are formed up front, the incoming carry
  // only drives the final mux.
  function automatic logic [4:0] csel(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [4:0] sum_c0;
    logic [4:0] sum_c1;
    sum_c0 = {1'b0, x} + {1'b0, y};
    sum_c1 = {1'b0, x} + {1'b0, y} + 5'd1;
    return cin ? sum_c1 : sum_c0;
  endfunction

  // Stage 0: nibble 0 done, bits [15:4] still pending
  logic        v0;
  logic [3:0]  d0;
  logic        c0;
  logic [15:4] a0;
  logic [15:4] nb0;
  // Stage 1
  logic        v1;
  logic [7:0]  d1;
  logic        c1;
  logic [15:8] a1;
  logic [15:8] nb1;
  // Stage 2
  logic        v2;
  logic [11:0] d2;
  logic        c2;
  logic [15:12] a2;
  logic [15:12] nb2;

  logic        ld0, ld1, ld2, ld3;
  logic        take;
  logic [15:0] nb_in;
  logic [4:0]  n0, n1, n2, n3;

  // A stage may load when it is empty or its occupant moves on this cycle.
  assign ld3      = !out_valid || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign ld0      = !v0 || ld1;
  assign in_ready = !rst && ld0;
  assign take     = in_valid && in_ready;

  assign nb_in = ~b;
  assign n0    = csel(a[3:0],     nb_in[3:0],  ~bin);
  assign n1    = csel(a0[7:4],    nb0[7:4],    c0);
  assign n2    = csel(a1[11:8],   nb1[11:8],   c1);
  assign n3    = csel(a2[15:12],  nb2[15:12],  c2);

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (ld0) v0 <= take;
      // NOTE: datapath registers are not reset; they only load alongside a
      // valid token, so stale contents never reach the outputs.
      if (take) begin
        d0  <= n0[3:0];
        c0  <= n0[4];
        a0  <= a[15:4];
        nb0 <= nb_in[15:4];
      end

      if (ld1) v1 <= v0;
      if (ld1 && v0) begin
        d1  <= {n1[3:0], d0};
        c1  <= n1[4];
        a1  <= a0[15:8];
        nb1 <= nb0[15:8];
      end

      if (ld2) v2 <= v1;
      if (ld2 && v1) begin
        d2  <= {n2[3:0], d1};
        c2  <= n2[4];
        a2  <= a1[15:12];
        nb2 <= nb1[15:12];
      end

      if (ld3) out_valid <= v2;
      if (ld3 && v2) begin
        diff <= {n3[3:0], d2};
        bout <= ~n3[4];
        // Operand signs differ exactly when a[15] equals the inverted b[15].
        ovf  <= (a2[15] == nb2[15]) && (n3[3] != a2[15]);
      end
    end
  end

endmodule

// File: tb/tb_csa_subtractor_pipe16.sv
// Self-checking bench: directed vectors, backpressured and random streams
// against an arithmetic reference, and a mid-flight reset.
module tb_csa_subtractor_pipe16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        bin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [17:0] q[$];

  csa_subtractor_pipe16 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {diff, bout, ovf}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin);
    int ua, ub, sd;
    logic [15:0] d;
    ua = int'(ma);
    ub = int'(mb);
    sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    d  = 16'(ua - ub - int'(mbin));
    return {d, ua < ub + int'(mbin), (sd < -32768) || (sd > 32767)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble();
    a   = 16'($urandom);
    b   = 16'($urandom);
    bin = 1'($urandom);
  endtask

  // One isolated operation on an empty pipe; checks latency, value, 1-cycle pulse.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tbin, input logic [15:0] ed, input logic eb,
                         input logic eo);
    int lat;
    in_valid = 1'b1; a = ta; b = tb; bin = tbin; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 10) begin
      next_cycle();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " result"}, 32'({diff, bout, ovf}), 32'({ed, eb, eo}));
    next_cycle();
    check({tag, " pulse width"}, 32'(out_valid), 32'd0);
  endtask

  // Streams n operations through the scoreboard; rnd selects random handshakes,
  // otherwise back-to-back input with out_ready low on cycles 5-8.
  task automatic stream(input int n, input bit rnd);
    int sent = 0, got = 0, stalls = 0, cyc = 0;
    bit hold = 1'b0;
    logic [18:0] held = '0;
    logic [17:0] exp;
    while (got < n && cyc < 400) begin
      cyc++;
      in_valid  = (sent < n) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      scramble();
      out_ready = rnd ? ($urandom_range(2) != 0) : !(cyc >= 5 && cyc <= 8);
      #1;
      if (hold) check("held output", 32'({out_valid, diff, bout, ovf}), 32'(held));
      hold = out_valid && !out_ready;
      held = {out_valid, diff, bout, ovf};
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      if (out_valid && out_ready) begin
        check("result expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          check("stream result", 32'({diff, bout, ovf}), 32'(exp));
        end
        got++;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    check("stream count", 32'(got), 32'(n));
    check("stream drained", 32'(q.size()), 32'd0);
    if (!rnd) check("stall cycles", 32'(stalls), 32'd4);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    scramble();
    @(negedge clk);
    #1 check("in_ready during reset", 32'(in_ready), 32'd0);
    next_cycle();
    check("reset outputs", 32'({out_valid, diff, bout, ovf}), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("in_ready after reset", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_one("5-3",          16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_one("0-1",          16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_one("equal bin",    16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_one("neg ovf",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_one("pos ovf",      16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_one("ripple hi",    16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("ripple lo",    16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

    stream(8, 1'b0);
    stream(60, 1'b1);

    // Three operations in flight, then a one-cycle reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      scramble();
      next_cycle();
    end
    rst = 1'b1;
    #1 check("in_ready in mid reset", 32'(in_ready), 32'd0);
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    check("out_valid after mid reset", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (out_valid) seen++;
    end
    check("flushed results", 32'(seen), 32'd0);
    run_one("post reset",   16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
